rect_filler: RTL and testbench

- Parametrised successor to the full-frame filler: fills an arbitrary clipped rectangle (x0,y0)-(x1,y1) of a frame buffer with one 24-bit colour.
- Sits beside the line engine under the graphics processor and drives the shared DRAM address FIFO (af) and write-data FIFO (wdf).
- Works in 8-pixel bursts: one af entry followed by two 128-bit wdf beats.
- Uses per-pixel write masks to cover partial blocks at the rectangle's left and right edges.

---
 rtl/rect_filler.sv | 153 +++++++++++++++
 tb/tb_rect_filler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rect_filler.sv
// rect_filler: fills a clipped rectangle of the frame buffer with one colour,
// emitting 8-pixel bursts (one af entry + two masked 128-bit wdf beats).
module rect_filler #(
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int X_W   = 10,
  parameter int Y_W   = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid,
  output logic           ready,
  input  logic [23:0]    color,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic [31:0]    frame_base,
  input  logic           af_full,
  input  logic           wdf_full,
  output logic [30:0]    af_addr_din,
  output logic           af_wr_en,
  output logic [127:0]   wdf_din,
  output logic [15:0]    wdf_mask_din,
  output logic           wdf_wr_en,
  output logic           done
);

  localparam int B_W = X_W - 3;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic [23:0]    col;
  logic [8:0]     base;
  logic [X_W-1:0] xs_r;
  logic [X_W-1:0] xe_r;
  logic [Y_W-1:0] ye_r;
  logic [Y_W-1:0] y_r;
  logic [B_W-1:0] xb;
  logic [X_W-1:0] x1c;
  logic [Y_W-1:0] y1c;
  logic           empty;
  logic           last_blk;
  logic           last_line;
  logic [7:0]     pix_on;
  logic [31:0]    word;
  logic           unused_base;

  assign unused_base = ^{frame_base[31], frame_base[21:0]};

  assign x1c = (x1 > X_MAX) ? X_MAX : x1;
  assign y1c = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty = (x0 > x1c) || (y0 > y1c) ||
                 (x0 > X_MAX) || (y0 > Y_MAX);

  assign last_blk  = (xb == xe_r[X_W-1:3]);
  assign last_line = (y_r == ye_r);
  assign word      = {8'h00, col};

  // Per-pixel coverage of the current block against the clipped span
  always_comb begin
    pix_on = '0;
    for (int p = 0; p < 8; p++) begin
      pix_on[p] = ({xb, 3'(p)} >= xs_r) &&
                  ({xb, 3'(p)} <= xe_r);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Command latch and block/line traversal
  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      base <= '0;
      xs_r <= '0;
      xe_r <= '0;
      ye_r <= '0;
      y_r  <= '0;
      xb   <= '0;
    end else if (ready && valid) begin
      col  <= color;
      base <= frame_base[30:22];
      xs_r <= x0;
      xe_r <= x1c;
      ye_r <= y1c;
      y_r  <= y0;
      xb   <= x0[X_W-1:3];
    end else if (state == BEAT1 && !wdf_full) begin
      if (last_blk) begin
        xb  <= xs_r[X_W-1:3];
        y_r <= y_r + 1'b1;
      end else begin
        xb <= xb + 1'b1;
      end
    end
  end

  // Next state and FIFO-facing outputs
  always_comb begin
    state_nx     = state;
    ready        = 1'b0;
    done         = 1'b0;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    af_addr_din  = '0;
    wdf_din      = '0;
    wdf_mask_din = '1;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (valid) state_nx = empty ? DONE : BEAT0;
      end
      BEAT0: begin
        af_addr_din  = {3'b000, base, 10'(y_r),
                        7'(xb), 2'b00};
        wdf_din      = {4{word}};
        wdf_mask_din = {{4{~pix_on[0]}}, {4{~pix_on[1]}},
                        {4{~pix_on[2]}}, {4{~pix_on[3]}}};
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_nx  = BEAT1;
        end
      end
      BEAT1: begin
        wdf_din      = {4{word}};
        wdf_mask_din = {{4{~pix_on[4]}}, {4{~pix_on[5]}},
                        {4{~pix_on[6]}}, {4{~pix_on[7]}}};
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          state_nx  = (last_blk && last_line) ? DONE : BEAT0;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (valid) state_nx = empty ? DONE : BEAT0;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rect_filler.sv
// tb_rect_filler: random and directed rectangle fills checked against
// a burst-list reference model built from the rectangle geometry.
module tb_rect_filler;

  localparam int H = 800;
  localparam int V = 600;

  logic         clk = 0;
  logic         rst = 1;
  logic         valid = 0;
  logic         ready;
  logic [23:0]  color = '0;
  logic [9:0]   x0 = '0;
  logic [9:0]   y0 = '0;
  logic [9:0]   x1 = '0;
  logic [9:0]   y1 = '0;
  logic [31:0]  frame_base = '0;
  logic         af_full = 0;
  logic         wdf_full = 0;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;
  logic         done;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_on = 0;

  logic [30:0]  aq[$];
  logic [143:0] wq[$];

  always #5 clk = ~clk;

  rect_filler #(.H_RES(H), .V_RES(V), .X_W(10), .Y_W(10)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready),
    .color(color), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .frame_base(frame_base), .af_full(af_full),
    .wdf_full(wdf_full), .af_addr_din(af_addr_din),
    .af_wr_en(af_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .done(done)
  );

  task automatic chk(input string tag, input logic [143:0] got,
                     input logic [143:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected bursts: every 8-pixel block of every clipped line, in raster order
  task automatic model(input int ax0, input int ay0, input int ax1,
                       input int ay1, input logic [23:0] c,
                       input logic [31:0] fb, output int blocks);
    int xe, ye;
    logic [30:0] a;
    logic [15:0] m;
    xe = (ax1 > H - 1) ? H - 1 : ax1;
    ye = (ay1 > V - 1) ? V - 1 : ay1;
    blocks = 0;
    if (ax0 > xe || ay0 > ye) return;
    for (int y = ay0; y <= ye; y++) begin
      for (int b = ax0 / 8; b <= xe / 8; b++) begin
        blocks++;
        a = (31'(fb[30:22]) << 19) | (31'(y) << 9) | (31'(b) << 2);
        aq.push_back(a);
        for (int h = 0; h < 2; h++) begin
          m = 16'h0000;
          for (int k = 0; k < 4; k++) begin
            int x;
            x = 8 * b + 4 * h + k;
            if (x < ax0 || x > xe) m = m | (16'hF << (12 - 4 * k));
          end
          wq.push_back({m, {4{8'h00, c}}});
        end
      end
    end
  endtask

  // Scoreboard on every push; no push may happen against a full FIFO
  always @(negedge clk) begin
    if (mon_on) begin
      if (af_full)  chk("af_stall", 144'(af_wr_en), 144'(0));
      if (wdf_full) chk("wdf_stall", 144'(wdf_wr_en), 144'(0));
      if (af_wr_en) begin
        chk("af_extra", 144'(aq.size() > 0), 144'(1));
        if (aq.size() > 0) chk("af_addr", 144'(af_addr_din), 144'(aq.pop_front()));
      end
      if (wdf_wr_en) begin
        chk("wdf_extra", 144'(wq.size() > 0), 144'(1));
        if (wq.size() > 0) chk("wdf_beat", {wdf_mask_din, wdf_din}, wq.pop_front());
      end
    end
  end

  // mode 0: no stall, 1: random stall, 2: scripted af then wdf stall
  task automatic run(input int ax0, input int ay0, input int ax1,
                     input int ay1, input int mode);
    int blocks, cyc;
    bit got;
    logic [23:0] c;
    logic [31:0] fb;
    logic [143:0] held;
    c = 24'($urandom);
    fb = $urandom & 32'hFFC0_0000;
    if (ax0 == 3 && ay0 == 2) begin
      c = 24'hAABBCC;
      fb = 32'h1040_0000;
    end
    model(ax0, ay0, ax1, ay1, c, fb, blocks);
    @(negedge clk);
    chk("ready_idle", 144'(ready), 144'(1));
    valid = 1; color = c; frame_base = fb;
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    @(posedge clk);
    #1;
    valid = 0;
    x0 = 10'($urandom); x1 = 10'($urandom);
    color = 24'($urandom);
    cyc = 0; got = 0; held = '0;
    while (!got && cyc < 5000) begin
      case (mode)
        1: begin
          af_full  = ($urandom_range(0, 3) == 0);
          wdf_full = ($urandom_range(0, 3) == 0);
        end
        2: begin
          af_full  = (cyc < 5);
          wdf_full = (cyc >= 6 && cyc < 9);
        end
        default: begin
          af_full = 0; wdf_full = 0;
        end
      endcase
      @(negedge clk);
      if (mode == 2 && cyc < 5)
        chk("af_hold", 144'({af_wr_en, wdf_wr_en}), 144'(0));
      if (mode == 2 && cyc == 6) held = {wdf_mask_din, wdf_din};
      if (mode == 2 && cyc == 9) begin
        chk("stall_push", 144'(wdf_wr_en), 144'(1));
        chk("stall_hold", {wdf_mask_din, wdf_din}, held);
      end
      if (done) begin
        got = 1;
        chk("ready_done", 144'(ready), 144'(1));
        if (mode == 0) chk("latency", 144'(cyc + 1), 144'(1 + 2 * blocks));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    af_full = 0; wdf_full = 0;
    chk("done_seen", 144'(got), 144'(1));
    chk("af_left", 144'(aq.size()), 144'(0));
    chk("wdf_left", 144'(wq.size()), 144'(0));
    aq.delete(); wq.delete();
    @(negedge clk);
    chk("done_pulse", 144'(done), 144'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", 144'(ready), 144'(1));
    chk("rst_done", 144'(done), 144'(0));
    chk("rst_en", 144'({af_wr_en, wdf_wr_en}), 144'(0));
    chk("rst_addr", 144'(af_addr_din), 144'(0));
    chk("rst_din", 144'(wdf_din), 144'(0));
    chk("rst_mask", 144'(wdf_mask_din), 144'(16'hFFFF));
    mon_on = 1;

    run(3, 2, 3, 2, 0);
    run(0, 0, 15, 0, 0);
    run(5, 1, 10, 2, 2);
    run(790, 599, 1023, 1023, 0);
    run(20, 0, 10, 0, 0);
    run(100, 700, 120, 800, 0);

    mon_on = 0;
    @(negedge clk);
    valid = 1; x0 = 0; y0 = 0; x1 = 63; y1 = 3;
    @(posedge clk);
    #1 valid = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_en", 144'({af_wr_en, wdf_wr_en}), 144'(0));
    chk("mid_rst_ready", 144'(ready), 144'(1));
    @(negedge clk);
    chk("mid_rst_idle", 144'({af_wr_en, wdf_wr_en}), 144'(0));
    aq.delete(); wq.delete();
    mon_on = 1;
    run(9, 4, 30, 5, 0);

    for (int i = 0; i < 60; i++) begin
      int rx0, ry0, rx1, ry1;
      rx0 = $urandom_range(0, 850);
      ry0 = $urandom_range(0, 620);
      rx1 = rx0 + $urandom_range(0, 40) - 4;
      ry1 = ry0 + $urandom_range(0, 3);
      if (i % 10 == 0) rx1 = 1023;
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 1023) rx1 = 1023;
      if (ry1 > 1023) ry1 = 1023;
      if (i % 10 == 0) rx0 = $urandom_range(760, 805);
      run(rx0, ry0, rx1, ry1, int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
